mem_bus_arbiter: RTL

Two-master, one-slave arbiter. It shares the single memory port between instruction fetch (master 0, IFU, read-only) and load/store (master 1, LSU, read/write). One transaction is outstanding at a time, and the grant is held from request acceptance until the response handshake completes. Round-robin arbitration prevents starvation.

---
 rtl/mem_bus_pkg.sv | 18 +
 rtl/mem_bus_arbiter_if.sv | 53 +++++
 rtl/mem_bus_arbiter_rr_arbiter2.sv | 22 ++
 rtl/mem_bus_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared definitions for the two-master memory bus arbiter: FSM encoding,
// response codes and master identifiers.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_RESP  = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;

  localparam logic IFU = 1'b0;
  localparam logic LSU = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the IFU, LSU and memory-side handshake signals around the arbiter.
// arb is the arbiter's view; master and slave are the requester and memory views.
interface mem_bus_arbiter_if;

  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_req_addr;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready;

  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_req_addr;
  logic [31:0] lsu_req_wdata;
  logic [3:0]  lsu_req_wstrb;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready;

  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;

  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wstrb;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic [1:0]  mem_resp_err;

  modport arb (
    input  ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    input  lsu_req_valid, lsu_req_addr, lsu_req_wdata, lsu_req_wstrb, lsu_resp_ready,
    output ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
    output resp_rdata, resp_err,
    output mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_resp_ready,
    input  mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

  modport master (
    output ifu_req_valid, ifu_req_addr, ifu_resp_ready,
    output lsu_req_valid, lsu_req_addr, lsu_req_wdata, lsu_req_wstrb, lsu_resp_ready,
    input  ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wstrb, mem_resp_ready,
    output mem_req_ready, mem_resp_valid, mem_resp_rdata, mem_resp_err
  );

endinterface

// File: rtl/mem_bus_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin select: a lone requester wins, and on a
// conflict the master that was not granted last time wins.
module rr_arbiter2
  import mem_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       any_req,
  output logic       winner
);

  always_comb begin
    any_req = |req;
    case (req)
      2'b01:   winner = IFU;
      2'b10:   winner = LSU;
      2'b11:   winner = ~last;
      default: winner = IFU;
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (IFU/LSU) to one-slave memory arbiter, one transaction in flight.
// Define ARB_TIMEOUT_EN to add the slave-progress timeout and the DRAIN state.
module mem_bus_arbiter
  import mem_bus_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic           clock,
  input  logic           reset,
  mem_bus_arbiter_if.arb bus
);

  state_e      state_reg, state_next;
  logic        grant_reg, grant_next;
  logic        last_reg, last_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [3:0]  wstrb_reg, wstrb_next;

  logic        any_req;
  logic        winner;
  logic        gnt_resp_ready;
  logic        resp_valid_sel;
  logic        ifu_ready, lsu_ready;
  logic        req_valid, resp_ready;
  logic [31:0] rdata_out;
  logic [1:0]  err_out;
  logic        timed_out;

  rr_arbiter2 u_rr (
    .req     ({bus.lsu_req_valid, bus.ifu_req_valid}),
    .last    (last_reg),
    .any_req (any_req),
    .winner  (winner)
  );

  assign gnt_resp_ready = (grant_reg == LSU) ? bus.lsu_resp_ready : bus.ifu_resp_ready;

`ifdef ARB_TIMEOUT_EN
  logic [31:0] cnt_reg, cnt_next;
  logic        slave_hs;

  assign timed_out = (cnt_reg == TIMEOUT_CYCLES);
  assign slave_hs  = (req_valid && bus.mem_req_ready) || (resp_ready && bus.mem_resp_valid);

  // Counter restarts on every state change so each phase gets a full window.
  always_comb begin
    cnt_next = cnt_reg;
    if (state_reg == S_IDLE || state_next != state_reg || slave_hs) begin
      cnt_next = '0;
    end else if (!timed_out) begin
      cnt_next = cnt_reg + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    last_next      = last_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    wstrb_next     = wstrb_reg;
    ifu_ready      = 1'b0;
    lsu_ready      = 1'b0;
    req_valid      = 1'b0;
    resp_ready     = 1'b0;
    resp_valid_sel = 1'b0;
    rdata_out      = bus.mem_resp_rdata;
    err_out        = bus.mem_resp_err;

    case (state_reg)
      S_IDLE: begin
        if (any_req && !reset) begin
          ifu_ready  = (winner == IFU);
          lsu_ready  = (winner == LSU);
          grant_next = winner;
          last_next  = winner;
          state_next = S_REQ;
          if (winner == IFU) begin
            addr_next  = bus.ifu_req_addr;
            wdata_next = '0;
            wstrb_next = '0;
          end else begin
            addr_next  = bus.lsu_req_addr;
            wdata_next = bus.lsu_req_wdata;
            wstrb_next = bus.lsu_req_wstrb;
          end
        end
      end

      S_REQ: begin
        if (timed_out) begin
          resp_valid_sel = 1'b1;
          rdata_out      = '0;
          err_out        = RESP_SLVERR;
          if (gnt_resp_ready) state_next = S_IDLE;
        end else begin
          req_valid = 1'b1;
          if (bus.mem_req_ready) state_next = S_RESP;
        end
      end

      S_RESP: begin
        // After a timeout the slave's late response is swallowed in DRAIN.
        if (timed_out) begin
          resp_valid_sel = 1'b1;
          rdata_out      = '0;
          err_out        = RESP_SLVERR;
          if (gnt_resp_ready) state_next = S_DRAIN;
        end else begin
          resp_ready     = gnt_resp_ready;
          resp_valid_sel = bus.mem_resp_valid;
          if (bus.mem_resp_valid && gnt_resp_ready) state_next = S_IDLE;
        end
      end

`ifdef ARB_TIMEOUT_EN
      S_DRAIN: begin
        resp_ready = 1'b1;
        if (bus.mem_resp_valid || timed_out) state_next = S_IDLE;
      end
`endif

      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= S_IDLE;
      grant_reg <= IFU;
      last_reg  <= LSU;
      addr_reg  <= '0;
      wdata_reg <= '0;
      wstrb_reg <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      wstrb_reg <= wstrb_next;
    end
  end

  assign bus.ifu_req_ready  = ifu_ready;
  assign bus.lsu_req_ready  = lsu_ready;
  assign bus.ifu_resp_valid = resp_valid_sel && (grant_reg == IFU);
  assign bus.lsu_resp_valid = resp_valid_sel && (grant_reg == LSU);
  assign bus.resp_rdata     = rdata_out;
  assign bus.resp_err       = err_out;
  assign bus.mem_req_valid  = req_valid;
  assign bus.mem_req_addr   = addr_reg;
  assign bus.mem_req_wdata  = wdata_reg;
  assign bus.mem_req_wstrb  = wstrb_reg;
  assign bus.mem_resp_ready = resp_ready;

endmodule
